plic_claim_ctrl: RTL and testbench
==================================

Name: plic_claim_ctrl

Overview:
- Hardware claim/complete sequencer for one interrupt target of the platform-level interrupt controller.
- Watches the target's irq/irq_id outputs and performs the claim read of the target CC register over a simple req/gnt register port.
- Delivers the claimed ID to a consumer (hart shim or DMA engine) through a valid/ready handshake, then writes the completion back.
- Sits between the interrupt controller's register interface (via a host-side TL-UL adapter) and the interrupt consumer, so software never touches CC directly.

Parameters:
- NumSrc, 64, number of interrupt sources; SRCW = $clog2(NumSrc) is derived.
- CcAddr, 32'h0020_0004, byte address of the target's CC register.
- TimeoutCycles, 1024, service cycles before a forced completion; legal range 2..65535.
- HoldoffCycles, 2, idle cycles after completion before the next claim; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  enables new claims; when 0, an in-flight sequence still finishes
- irq_i  in  1  target interrupt request
- irq_id_i  in  SRCW+1  target's current highest-priority ID (informational only)
- req_o  out  1  register access request
- we_o  out  1  1 = write, 0 = read
- addr_o  out  32  access address, always CcAddr
- wdata_o  out  32  write data: zero-extended ID
- gnt_i  in  1  request accepted this cycle
- rvalid_i  in  1  response valid
- rdata_i  in  32  read response data
- id_valid_o  out  1  claimed ID available to the consumer
- id_o  out  SRCW+1  claimed ID
- id_ready_i  in  1  consumer accepts the ID
- done_i  in  1  consumer finished servicing (single-cycle pulse)
- busy_o  out  1  FSM not in IDLE
- spurious_o  out  1  one-cycle pulse: claim returned ID 0
- timeout_o  out  1  one-cycle pulse: forced completion

Behaviour:
- Reset: FSM=IDLE; req_o, we_o, id_valid_o, busy_o, spurious_o, timeout_o all 0; id_o=0; wdata_o=0; addr_o=CcAddr; counters=0. Asynchronous reset mid-sequence abandons the access with no completion write; the interrupt controller is reset alongside.
- States and transitions:
  - IDLE: go to CLAIM_REQ when irq_i && en_i.
  - CLAIM_REQ: req_o=1, we_o=0; hold both until gnt_i, then go to CLAIM_RSP.
  - CLAIM_RSP: on rvalid_i, capture rdata_i[SRCW:0] into the ID register. If ID==0, pulse spurious_o and go to HOLDOFF. Otherwise go to DELIVER.
  - DELIVER: id_valid_o=1 and id_o stable until id_ready_i; on the handshake go to SERVICE and clear the timer.
  - SERVICE: timer increments each cycle. done_i goes to COMPLETE_REQ. When the timer reaches TimeoutCycles-1 without done_i, pulse timeout_o and go to COMPLETE_REQ. done_i on that same cycle wins: no timeout pulse.
  - COMPLETE_REQ: req_o=1, we_o=1, wdata_o = zero-extended ID; hold until gnt_i, then go to COMPLETE_RSP.
  - COMPLETE_RSP: on rvalid_i go to HOLDOFF.
  - HOLDOFF: wait HoldoffCycles cycles so the gateway ip and target irq settle, then go to IDLE.
- Bus rules:
  - req_o, we_o, addr_o and wdata_o are stable while req_o=1 && !gnt_i.
  - rvalid_i is never before the cycle after gnt_i.
  - rvalid_i outside the RSP states is ignored.
  - At most one outstanding access.
- Latency: irq_i rising to req_o is 1 cycle (registered FSM). With gnt_i and rvalid_i both zero-wait, irq_i to id_valid_o is 3 cycles.
- done_i is ignored outside SERVICE. id_ready_i is ignored outside DELIVER.
- Dropping irq_i after IDLE has no effect on the sequence. The claim result decides, and ID 0 handles the withdrawn case.
- Clearing en_i mid-sequence does not stop it; only re-entry from IDLE is blocked.
- All outputs are driven from registers. The timer is 16 bits and saturates; it never wraps.

Test Plan:
- Zero-wait bus; irq_i=1; rdata_i=5 on claim; id_ready_i=1; done_i 10 cycles later. Required: claim read at CcAddr; id_valid_o with id_o=5 three cycles after irq_i; write of wdata_o=5 after done_i; busy_o low HoldoffCycles cycles after the write rvalid_i.
- Claim returns rdata_i=0. Required: spurious_o pulses once; no id_valid_o; no write; FSM returns to IDLE after holdoff.
- TimeoutCycles=8; done_i never asserted. Required: timeout_o pulses exactly 8 cycles after the id handshake; completion write carries the claimed ID.
- gnt_i delayed 3 cycles and id_ready_i delayed 4 cycles. Required: req_o, we_o, addr_o, wdata_o held stable while waiting; id_o held stable while id_valid_o is high; no duplicate accesses.
- en_i=0 with irq_i=1. Required: no req_o. Then clear en_i during SERVICE. Required: completion still written; no new claim while irq_i stays high.
- Assert rst_ni low during COMPLETE_REQ. Required: all outputs 0 immediately (asynchronous); after release, FSM in IDLE.

Source files
------------

// File: rtl/plic_claim_ctrl.sv
// Claim/complete sequencer for one PLIC target: claims the pending ID over the
// register port, hands it to a consumer, then writes the completion back.
module plic_claim_ctrl #(
    parameter int          NumSrc        = 64,
    parameter logic [31:0] CcAddr        = 32'h0020_0004,
    parameter int          TimeoutCycles = 1024,
    parameter int          HoldoffCycles = 2,
    localparam int         SRCW          = $clog2(NumSrc)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            irq_i,
    input  logic [SRCW:0]   irq_id_i,
    output logic            req_o,
    output logic            we_o,
    output logic [31:0]     addr_o,
    output logic [31:0]     wdata_o,
    input  logic            gnt_i,
    input  logic            rvalid_i,
    input  logic [31:0]     rdata_i,
    output logic            id_valid_o,
    output logic [SRCW:0]   id_o,
    input  logic            id_ready_i,
    input  logic            done_i,
    output logic            busy_o,
    output logic            spurious_o,
    output logic            timeout_o,
    output logic [2:0]      dbg_state_o
);

    // Register port: req_o/we_o/addr_o/wdata_o hold steady from the cycle req_o
    // rises until the cycle gnt_i is seen high; the response (rvalid_i) is only
    // consumed in the matching RSP state. Consumer port: id_o is stable while
    // id_valid_o is high and the transfer happens on id_valid_o && id_ready_i.
    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_CLAIM_REQ    = 3'd1;
    localparam logic [2:0] S_CLAIM_RSP    = 3'd2;
    localparam logic [2:0] S_DELIVER      = 3'd3;
    localparam logic [2:0] S_SERVICE      = 3'd4;
    localparam logic [2:0] S_COMPLETE_REQ = 3'd5;
    localparam logic [2:0] S_COMPLETE_RSP = 3'd6;
    localparam logic [2:0] S_HOLDOFF      = 3'd7;

    localparam logic [15:0] ToLast  = 16'(TimeoutCycles - 1);
    localparam logic [15:0] HoLast  = 16'(HoldoffCycles - 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [SRCW:0] id_q, id_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          id_valid_q, id_valid_d;
    logic          busy_q, busy_d;
    logic          spurious_q, spurious_d;
    logic          timeout_q, timeout_d;

    // irq_id_i is informational; the claim read result is authoritative.
    logic unused_irq_id;
    assign unused_irq_id = ^irq_id_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        wdata_d    = wdata_q;
        spurious_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: if (irq_i && en_i) state_d = S_CLAIM_REQ;
            S_CLAIM_REQ: if (gnt_i) state_d = S_CLAIM_RSP;
            S_CLAIM_RSP: begin
                if (rvalid_i) begin
                    id_d = rdata_i[SRCW:0];
                    if (rdata_i[SRCW:0] == '0) begin
                        spurious_d = 1'b1;
                        state_d    = S_HOLDOFF;
                        cnt_d      = '0;
                    end else begin
                        state_d = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
                if (id_ready_i) begin
                    state_d = S_SERVICE;
                    cnt_d   = '0;
                end
            end
            S_SERVICE: begin
                // done_i takes priority over a timeout landing on the same cycle.
                if (done_i) begin
                    state_d = S_COMPLETE_REQ;
                end else if (cnt_q == ToLast) begin
                    timeout_d = 1'b1;
                    state_d   = S_COMPLETE_REQ;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_COMPLETE_REQ: if (gnt_i) state_d = S_COMPLETE_RSP;
            S_COMPLETE_RSP: begin
                if (rvalid_i) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = '0;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q >= HoLast) state_d = S_IDLE;
                else                 cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        if (state_d == S_COMPLETE_REQ) wdata_d = {{(31 - SRCW){1'b0}}, id_q};
        req_d      = (state_d == S_CLAIM_REQ) || (state_d == S_COMPLETE_REQ);
        we_d       = (state_d == S_COMPLETE_REQ);
        id_valid_d = (state_d == S_DELIVER);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            id_q       <= '0;
            wdata_q    <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            id_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            spurious_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            wdata_q    <= wdata_d;
            req_q      <= req_d;
            we_q       <= we_d;
            id_valid_q <= id_valid_d;
            busy_q     <= busy_d;
            spurious_q <= spurious_d;
            timeout_q  <= timeout_d;
        end
    end

    assign req_o       = req_q;
    assign we_o        = we_q;
    assign addr_o      = CcAddr;
    assign wdata_o     = wdata_q;
    assign id_valid_o  = id_valid_q;
    assign id_o        = id_q;
    assign busy_o      = busy_q;
    assign spurious_o  = spurious_q;
    assign timeout_o   = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Bench for plic_claim_ctrl: directed sequences, a bus responder that checks
// every accepted access against a queue, and an ID monitor with its own queue.
module tb_plic_claim_ctrl;

    localparam int          SRCW = 6;
    localparam logic [31:0] CC   = 32'h0020_0004;
    localparam logic [2:0]  S_IDLE = 3'd0, S_SERVICE = 3'd4, S_CREQ = 3'd5, S_HOLD = 3'd7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en_i, irq_i, gnt_i, rvalid_i, id_ready_i, done_i;
    logic [SRCW:0]   irq_id_i;
    logic [31:0]     rdata_i;
    logic            req_o, we_o, id_valid_o, busy_o, spurious_o, timeout_o;
    logic [31:0]     addr_o, wdata_o;
    logic [SRCW:0]   id_o;
    logic [2:0]      dbg_state_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [64:0]   exp_acc_q[$];
    logic [SRCW:0] exp_id_q[$];

    int          gnt_delay = 0;
    bit          bus_hold = 1'b0;
    logic [31:0] claim_data = 32'h0;
    int          spur_cnt = 0;
    int          to_cnt = 0;

    plic_claim_ctrl #(
        .NumSrc(64), .CcAddr(CC), .TimeoutCycles(8), .HoldoffCycles(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .irq_i(irq_i), .irq_id_i(irq_id_i),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .id_valid_o(id_valid_o), .id_o(id_o), .id_ready_i(id_ready_i),
        .done_i(done_i), .busy_o(busy_o), .spurious_o(spurious_o),
        .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // bus responder: grants after gnt_delay waiting cycles, answers the cycle after
    task automatic push_read();
        exp_acc_q.push_back({1'b0, CC, 32'h0});
    endtask

    task automatic push_write(input logic [31:0] d);
        exp_acc_q.push_back({1'b1, CC, d});
    endtask

    initial begin : responder
        bit          req_seen;
        logic        s_we;
        logic [31:0] s_addr, s_wdata;
        logic [64:0] e;
        int          wait_cnt;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0;
        req_seen = 1'b0; s_we = 1'b0; s_addr = 32'h0; s_wdata = 32'h0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            rvalid_i = 1'b0;
            if (gnt_i && req_seen) begin
                if (exp_acc_q.size() == 0) begin
                    tests_run++; tests_failed++;
                    $display("FAIL unexpected_access: got we=%0d wdata=%0h, required no access (t=%0t)",
                             s_we, s_wdata, $time);
                end else begin
                    e = exp_acc_q.pop_front();
                    chk("bus_access", {s_we, s_addr, (s_we ? s_wdata : 32'h0)}, e);
                end
                rvalid_i = 1'b1;
                rdata_i  = s_we ? 32'h0 : claim_data;
            end else if (req_seen && req_o) begin
                chk("bus_stable", {1'b1, we_o, addr_o, wdata_o}, {1'b1, s_we, s_addr, s_wdata});
            end
            gnt_i = (req_o && !bus_hold && wait_cnt >= gnt_delay);
            if (req_o) wait_cnt++;
            else       wait_cnt = 0;
            req_seen = req_o; s_we = we_o; s_addr = addr_o; s_wdata = wdata_o;
        end
    end

    // ID monitor plus pulse counters, sampled mid low-phase
    initial begin : id_monitor
        logic          p_v, p_r;
        logic [SRCW:0] p_id;
        p_v = 1'b0; p_r = 1'b0; p_id = '0;
        forever begin
            @(negedge clk);
            #2;
            if (spurious_o) spur_cnt++;
            if (timeout_o)  to_cnt++;
            if (p_v && !p_r && id_valid_o) chk("id_stable", 65'(id_o), 65'(p_id));
            if (id_valid_o && id_ready_i) begin
                if (exp_id_q.size() == 0) begin
                    tests_run++; tests_failed++;
                    $display("FAIL unexpected_id: got id=%0d, required no delivery (t=%0t)", id_o, $time);
                end else begin
                    chk("id_value", 65'(id_o), 65'(exp_id_q.pop_front()));
                end
            end
            p_v = id_valid_o; p_r = id_ready_i; p_id = id_o;
        end
    end

    // driver helpers
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while (busy_o && i < budget) begin tick(1); i++; end
        chk(name, 65'(busy_o), 65'd0);
    endtask

    task automatic wait_state(input string name, input logic [2:0] st, input int budget);
        int i = 0;
        while (dbg_state_o != st && i < budget) begin tick(1); i++; end
        chk(name, 65'(dbg_state_o), 65'(st));
    endtask

    initial begin : main
        int s0, t0, i;
        rst_n = 1'b1; en_i = 1'b0; irq_i = 1'b0; irq_id_i = '0;
        id_ready_i = 1'b0; done_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {req_o, we_o, id_valid_o, busy_o, spurious_o, timeout_o},
            65'd0);
        chk("rst_id_wdata", {id_o, wdata_o}, 65'd0);
        chk("rst_addr", 65'(addr_o), 65'(CC));
        chk("rst_state", 65'(dbg_state_o), 65'(S_IDLE));
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // 1: zero-wait claim of ID 5, done 10 cycles after irq
        claim_data = 32'd5; gnt_delay = 0; en_i = 1'b1; id_ready_i = 1'b1;
        push_read(); push_write(32'd5); exp_id_q.push_back(7'd5);
        t0 = to_cnt;
        tick(1);
        irq_i = 1'b1; irq_id_i = 7'd5;
        tick(1);
        chk("t1_req_latency", {req_o, we_o}, 65'b10);
        irq_i = 1'b0; irq_id_i = '0;
        tick(1);
        chk("t1_no_early_valid", 65'(id_valid_o), 65'd0);
        tick(1);
        chk("t1_valid_latency", {id_valid_o, id_o}, {1'b1, 7'd5});
        tick(6);
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        chk("t1_complete_req", {req_o, we_o, wdata_o}, {2'b11, 32'd5});
        tick(2);
        chk("t1_holdoff_0", {busy_o, dbg_state_o}, {1'b1, S_HOLD});
        tick(1);
        chk("t1_holdoff_1", 65'(busy_o), 65'd1);
        tick(1);
        chk("t1_idle_after_holdoff", 65'(busy_o), 65'd0);
        chk("t1_no_timeout", 65'(to_cnt - t0), 65'd0);

        // 2: spurious claim (ID 0)
        claim_data = 32'd0; push_read(); s0 = spur_cnt;
        tick(1);
        irq_i = 1'b1;
        tick(1);
        irq_i = 1'b0;
        tick(2);
        chk("t2_spurious_pulse", {spurious_o, id_valid_o}, 65'b10);
        tick(1);
        chk("t2_spurious_one_cycle", {spurious_o, busy_o}, 65'b01);
        tick(1);
        chk("t2_idle", 65'(busy_o), 65'd0);
        tick(1);
        chk("t2_spur_count", 65'(spur_cnt - s0), 65'd1);

        // 3: no done -> forced completion 8 cycles after the handshake
        claim_data = 32'd9; push_read(); push_write(32'd9); exp_id_q.push_back(7'd9);
        t0 = to_cnt;
        tick(1);
        irq_i = 1'b1;
        tick(1);
        irq_i = 1'b0;
        tick(10);
        chk("t3_no_early_timeout", 65'(timeout_o), 65'd0);
        tick(1);
        chk("t3_timeout_pulse", {timeout_o, req_o, we_o, wdata_o}, {3'b111, 32'd9});
        tick(1);
        chk("t3_timeout_one_cycle", 65'(timeout_o), 65'd0);
        wait_idle("t3_idle", 10);
        chk("t3_timeout_count", 65'(to_cnt - t0), 65'd1);

        // 4: slow grant and slow consumer
        claim_data = 32'd12; gnt_delay = 3; id_ready_i = 1'b0;
        push_read(); push_write(32'd12); exp_id_q.push_back(7'd12);
        tick(1);
        irq_i = 1'b1;
        tick(1);
        chk("t4_req", 65'(req_o), 65'd1);
        irq_i = 1'b0;
        i = 0;
        while (!id_valid_o && i < 20) begin tick(1); i++; end
        chk("t4_id_valid", {id_valid_o, id_o}, {1'b1, 7'd12});
        tick(4);
        id_ready_i = 1'b1;
        tick(1);
        id_ready_i = 1'b0;
        chk("t4_service", 65'(dbg_state_o), 65'(S_SERVICE));
        tick(2);
        pulse_done();
        wait_idle("t4_idle", 40);
        gnt_delay = 0;

        // 5: enable gating
        claim_data = 32'd7; en_i = 1'b0; id_ready_i = 1'b1;
        tick(1);
        irq_i = 1'b1;
        tick(10);
        chk("t5_blocked", {busy_o, req_o}, 65'd0);
        push_read(); push_write(32'd7); exp_id_q.push_back(7'd7);
        en_i = 1'b1;
        wait_state("t5_service", S_SERVICE, 20);
        en_i = 1'b0;
        tick(2);
        pulse_done();
        wait_idle("t5_idle", 20);
        tick(10);
        chk("t5_no_reclaim", {busy_o, req_o}, 65'd0);
        irq_i = 1'b0;

        // 6: asynchronous reset while the completion write is pending
        claim_data = 32'd3; en_i = 1'b1;
        push_read(); exp_id_q.push_back(7'd3);
        tick(1);
        irq_i = 1'b1;
        tick(1);
        irq_i = 1'b0;
        wait_state("t6_service", S_SERVICE, 20);
        bus_hold = 1'b1;
        tick(1);
        pulse_done();
        wait_state("t6_complete_req", S_CREQ, 5);
        tick(1);
        chk("t6_req_held", {req_o, we_o, wdata_o}, {2'b11, 32'd3});
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_outputs", {req_o, we_o, id_valid_o, busy_o, spurious_o, timeout_o},
            65'd0);
        chk("t6_async_regs", {dbg_state_o, id_o, wdata_o}, 65'd0);
        tick(1);
        bus_hold = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(4);
        chk("t6_idle_after_reset", {busy_o, req_o, dbg_state_o}, 65'd0);

        chk("acc_queue_drained", 65'(exp_acc_q.size()), 65'd0);
        chk("id_queue_drained", 65'(exp_id_q.size()), 65'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
